// File: rtl/controle_varredura_servo.sv
// Servo sweep sequencer: steps the PWM width code between POS_MIN and POS_MAX,
// settling at each position and requesting one range measurement.
module controle_varredura_servo #(
    parameter int unsigned CICLOS_ACOMODA = 25_000_000,
    parameter int unsigned CICLOS_TIMEOUT = 50_000_000,
    parameter int unsigned POS_MIN        = 0,
    parameter int unsigned POS_MAX        = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       zerar,
    input  logic       medida_pronta,
    output logic [2:0] largura,
    output logic       sentido,
    output logic       pedir_medida,
    output logic       fim_varredura,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        PARADO  = 4'd0,
        ACOMODA = 4'd1,
        MEDE    = 4'd2,
        AGUARDA = 4'd3,
        AVANCA  = 4'd4
    } estado_t;

    localparam logic [31:0] LIM_ACOMODA = 32'(CICLOS_ACOMODA - 1);
    localparam logic [31:0] LIM_TIMEOUT = 32'(CICLOS_TIMEOUT - 1);
    localparam logic [2:0]  L_MIN       = 3'(POS_MIN);
    localparam logic [2:0]  L_MAX       = 3'(POS_MAX);

    estado_t     r_estado;
    logic [31:0] r_cont;
    logic [2:0]  r_largura;
    logic        r_sentido;
    logic        r_fim;
    logic        r_timeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado  <= PARADO;
            r_cont    <= '0;
            r_largura <= L_MIN;
            r_sentido <= 1'b1;
            r_fim     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_fim     <= 1'b0;
            // A timeout owed in the last wait cycle is reported even if stopping
            r_timeout <= (r_estado == AGUARDA) && !medida_pronta &&
                         (r_cont == LIM_TIMEOUT);
            if (r_estado != PARADO && !ligar) begin
                r_estado <= PARADO;
                r_cont   <= '0;
            end else begin
                unique case (r_estado)
                    PARADO: begin
                        if (ligar) begin
                            r_estado <= ACOMODA;
                            r_cont   <= '0;
                        end else if (zerar) begin
                            r_largura <= L_MIN;
                            r_sentido <= 1'b1;
                        end
                    end
                    ACOMODA: begin
                        if (r_cont == LIM_ACOMODA) begin
                            r_estado <= MEDE;
                            r_cont   <= '0;
                        end else begin
                            r_cont <= r_cont + 32'd1;
                        end
                    end
                    MEDE: begin
                        r_estado <= AGUARDA;
                        r_cont   <= '0;
                    end
                    AGUARDA: begin
                        if (medida_pronta || r_cont == LIM_TIMEOUT) begin
                            r_estado <= AVANCA;
                            r_cont   <= '0;
                        end else begin
                            r_cont <= r_cont + 32'd1;
                        end
                    end
                    AVANCA: begin
                        r_estado <= ACOMODA;
                        r_cont   <= '0;
                        if (r_sentido) begin
                            if (r_largura < L_MAX) begin
                                r_largura <= r_largura + 3'd1;
                            end else begin
                                r_sentido <= 1'b0;
                                r_largura <= L_MAX - 3'd1;
                                r_fim     <= 1'b1;
                            end
                        end else begin
                            if (r_largura > L_MIN) begin
                                r_largura <= r_largura - 3'd1;
                            end else begin
                                r_sentido <= 1'b1;
                                r_largura <= L_MIN + 3'd1;
                                r_fim     <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_estado <= PARADO;
                        r_cont   <= '0;
                    end
                endcase
            end
        end
    end

    assign largura       = r_largura;
    assign sentido       = r_sentido;
    assign pedir_medida  = (r_estado == MEDE);
    assign fim_varredura = r_fim;
    assign timeout       = r_timeout;
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_controle_varredura_servo.sv
// Bench for controle_varredura_servo: scenario tasks plus a scoreboard of
// expected positions, popped whenever the DUT leaves AVANCA.
module tb_controle_varredura_servo;

    localparam int ACO = 4;
    localparam int TMO = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic       zerar;
    logic       medida_pronta;
    logic [2:0] largura;
    logic       sentido;
    logic       pedir_medida;
    logic       fim_varredura;
    logic       timeout;
    logic [3:0] db_estado;

    int n_cmp = 0;
    int n_err = 0;
    int n_fim = 0;

    typedef struct packed {
        logic [2:0] larg;
        logic       sent;
        logic       fim;
    } esp_t;

    esp_t       fila[$];
    esp_t       e_mon;
    logic [2:0] m_larg;
    logic       m_sent;
    logic [3:0] db_ant = 4'd0;

    controle_varredura_servo #(
        .CICLOS_ACOMODA(ACO),
        .CICLOS_TIMEOUT(TMO),
        .POS_MIN(0),
        .POS_MAX(7)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ligar(ligar),
        .zerar(zerar),
        .medida_pronta(medida_pronta),
        .largura(largura),
        .sentido(sentido),
        .pedir_medida(pedir_medida),
        .fim_varredura(fim_varredura),
        .timeout(timeout),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Scoreboard: every AVANCA -> ACOMODA exit must match the oldest prediction
    always @(negedge clock) begin
        if (fim_varredura === 1'b1) n_fim++;
        if (db_ant == 4'd4 && db_estado == 4'd1) begin
            n_cmp++;
            if (fila.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard: unexpected advance, largura=%0d", largura);
            end else begin
                e_mon = fila.pop_front();
                if (largura !== e_mon.larg || sentido !== e_mon.sent ||
                    fim_varredura !== e_mon.fim) begin
                    n_err++;
                    $display("FAIL advance: largura=%0d sentido=%b fim=%b, required %0d %b %b",
                             largura, sentido, fim_varredura,
                             e_mon.larg, e_mon.sent, e_mon.fim);
                end
            end
        end
        db_ant = db_estado;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic prever();
        esp_t e;
        e.fim = 1'b0;
        if (m_sent && m_larg == 3'd7) begin
            m_sent = 1'b0;
            m_larg = 3'd6;
            e.fim  = 1'b1;
        end else if (!m_sent && m_larg == 3'd0) begin
            m_sent = 1'b1;
            m_larg = 3'd1;
            e.fim  = 1'b1;
        end else if (m_sent) begin
            m_larg = m_larg + 3'd1;
        end else begin
            m_larg = m_larg - 3'd1;
        end
        e.larg = m_larg;
        e.sent = m_sent;
        fila.push_back(e);
    endtask

    task automatic espera_pedido(input string nome);
        int n = 0;
        while (pedir_medida !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (pedir_medida !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: pedir_medida=%b after %0d cycles, required 1",
                     nome, pedir_medida, n);
        end
    endtask

    task automatic passo(input int atraso);
        espera_pedido("passo");
        prever();
        repeat (atraso) tick();
        medida_pronta = 1'b1;
        tick();
        medida_pronta = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ligar = 1'b0;
        zerar = 1'b0;
        medida_pronta = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (largura !== 3'd0 || sentido !== 1'b1 || db_estado !== 4'd0 ||
            pedir_medida !== 1'b0 || fim_varredura !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset: larg=%0d sent=%b db=%0d ped=%b fim=%b to=%b, required 0 1 0 0 0 0",
                     largura, sentido, db_estado, pedir_medida, fim_varredura, timeout);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (db_estado !== 4'd0) begin
            n_err++;
            $display("FAIL idle: db_estado=%0d, required 0", db_estado);
        end
        m_larg = 3'd0;
        m_sent = 1'b1;
    endtask

    task automatic test_primeira_medida();
        ligar = 1'b1;
        for (int i = 0; i < ACO; i++) begin
            tick();
            n_cmp++;
            if (db_estado !== 4'd1 || pedir_medida !== 1'b0) begin
                n_err++;
                $display("FAIL settle[%0d]: db=%0d ped=%b, required 1 0",
                         i, db_estado, pedir_medida);
            end
        end
        tick();
        n_cmp++;
        if (db_estado !== 4'd2 || pedir_medida !== 1'b1) begin
            n_err++;
            $display("FAIL request: db=%0d ped=%b, required 2 1", db_estado, pedir_medida);
        end
        prever();
        tick();
        n_cmp++;
        if (db_estado !== 4'd3 || pedir_medida !== 1'b0) begin
            n_err++;
            $display("FAIL request_len: db=%0d ped=%b, required 3 0", db_estado, pedir_medida);
        end
        repeat (2) tick();
        medida_pronta = 1'b1;
        tick();
        medida_pronta = 1'b0;
        n_cmp++;
        if (db_estado !== 4'd4) begin
            n_err++;
            $display("FAIL advance_state: db=%0d, required 4", db_estado);
        end
        tick();
        n_cmp++;
        if (db_estado !== 4'd1 || largura !== 3'd1) begin
            n_err++;
            $display("FAIL first_pos: db=%0d larg=%0d, required 1 1", db_estado, largura);
        end
    endtask

    task automatic test_varredura();
        int f0 = n_fim;
        repeat (14) passo(2);
        tick();
        n_cmp++;
        if (n_fim - f0 !== 2) begin
            n_err++;
            $display("FAIL fim_count: %0d pulses, required 2", n_fim - f0);
        end
    endtask

    task automatic test_timeout();
        espera_pedido("timeout_req");
        prever();
        for (int k = 1; k <= TMO; k++) begin
            tick();
            n_cmp++;
            if (timeout !== 1'b0 || db_estado !== 4'd3) begin
                n_err++;
                $display("FAIL wait[%0d]: to=%b db=%0d, required 0 3", k, timeout, db_estado);
            end
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b1 || db_estado !== 4'd4) begin
            n_err++;
            $display("FAIL timeout: to=%b db=%0d, required 1 4", timeout, db_estado);
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b0 || db_estado !== 4'd1) begin
            n_err++;
            $display("FAIL timeout_len: to=%b db=%0d, required 0 1", timeout, db_estado);
        end
        for (int k = 0; k < ACO - 1; k++) begin
            tick();
            n_cmp++;
            if (pedir_medida !== 1'b0) begin
                n_err++;
                $display("FAIL early_req[%0d]: ped=%b, required 0", k, pedir_medida);
            end
        end
        tick();
        n_cmp++;
        if (pedir_medida !== 1'b1) begin
            n_err++;
            $display("FAIL next_req: ped=%b, required 1", pedir_medida);
        end
    endtask

    task automatic test_medida_ultimo_ciclo();
        espera_pedido("last_req");
        prever();
        repeat (TMO) tick();
        medida_pronta = 1'b1;
        tick();
        medida_pronta = 1'b0;
        n_cmp++;
        if (db_estado !== 4'd4 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL last_cycle: db=%0d to=%b, required 4 0", db_estado, timeout);
        end
        repeat (4) tick();
        n_cmp++;
        if (largura !== m_larg || db_estado !== 4'd1 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL single_adv: larg=%0d db=%0d to=%b, required %0d 1 0",
                     largura, db_estado, timeout, m_larg);
        end
    endtask

    task automatic test_desligar_zerar();
        espera_pedido("stop_req");
        tick();
        ligar = 1'b0;
        tick();
        n_cmp++;
        if (db_estado !== 4'd0 || largura !== 3'd3) begin
            n_err++;
            $display("FAIL stop: db=%0d larg=%0d, required 0 3", db_estado, largura);
        end
        medida_pronta = 1'b1;
        tick();
        medida_pronta = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (db_estado !== 4'd0 || largura !== 3'd3 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL stray: db=%0d larg=%0d to=%b, required 0 3 0",
                     db_estado, largura, timeout);
        end
        zerar = 1'b1;
        tick();
        zerar = 1'b0;
        n_cmp++;
        if (largura !== 3'd0 || sentido !== 1'b1 || db_estado !== 4'd0) begin
            n_err++;
            $display("FAIL zerar: larg=%0d sent=%b db=%0d, required 0 1 0",
                     largura, sentido, db_estado);
        end
        m_larg = 3'd0;
        m_sent = 1'b1;
        ligar = 1'b1;
        passo(2);
        n_cmp++;
        if (largura !== 3'd1) begin
            n_err++;
            $display("FAIL resume: larg=%0d, required 1", largura);
        end
    endtask

    task automatic test_reset_aguarda();
        repeat (8) passo(1);
        espera_pedido("reset_req");
        n_cmp++;
        if (largura !== 3'd5 || sentido !== 1'b0) begin
            n_err++;
            $display("FAIL pre_reset: larg=%0d sent=%b, required 5 0", largura, sentido);
        end
        repeat (2) tick();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (largura !== 3'd0 || sentido !== 1'b1 || db_estado !== 4'd0 ||
            pedir_medida !== 1'b0 || fim_varredura !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: larg=%0d sent=%b db=%0d ped=%b fim=%b to=%b, required 0 1 0 0 0 0",
                     largura, sentido, db_estado, pedir_medida, fim_varredura, timeout);
        end
        tick();
        reset = 1'b0;
        ligar = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_primeira_medida();
        test_varredura();
        test_timeout();
        test_medida_ultimo_ciclo();
        test_desligar_zerar();
        test_reset_aguarda();
        n_cmp++;
        if (fila.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", fila.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
